i2c_cfg_writer: RTL and testbench

Serial I2C write master that consumes the 24-bit configuration words produced by the audio-codec init sequencer. Each word is {device address+W, register byte, data byte}, e.g. 8'h34 followed by 16 bits. The block shifts the word onto SCL/SDA, checks the three ACKs and signals completion on END, which the sequencer uses to advance its ROM address. It runs on the single 50 MHz system clock, using an internal tick divider instead of a derived clock.

---
 rtl/i2c_cfg_writer.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_cfg_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_writer.sv
// I2C write master for 24-bit codec configuration words (START, 3 bytes + ACKs, STOP).
// Optional NACK retry is compiled in with `define I2C_ACK_RETRY_EN.
module i2c_cfg_writer #(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        GO,
  input  logic [23:0] DATA,
  output logic        I2C_SCLK,
  output logic        I2C_SDAT_OE,
  input  logic        I2C_SDAT_IN,
  output logic        END,
  output logic        BUSY,
  output logic        ACK_ERR
);

  if (CLK_DIV < 2 || CLK_DIV > 1023 || MAX_RETRY > 15) begin : g_param_check
    $error("i2c_cfg_writer: CLK_DIV must be 2..1023 and MAX_RETRY at most 15");
  end

  localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA_BIT, S_ACK, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  ph_q, ph_d;
  logic        go_q;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_q, bit_d;
  logic        nack_q, nack_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;
  logic        end_q, end_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        launch, tick;
  logic        retry_ok, restart;
  logic [23:0] reload_w;

  assign launch = GO & ~go_q & (state_q == S_IDLE);
  assign tick   = (state_q != S_IDLE) && (cnt_q == DIV_M1);

`ifdef I2C_ACK_RETRY_EN
  localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);
  logic [23:0] word_q;
  logic [3:0]  retry_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      word_q  <= '0;
      retry_q <= '0;
    end else if (launch) begin
      word_q  <= DATA;
      retry_q <= '0;
    end else if (tick && state_q == S_STOP && ph_q == 2'd3 && restart) begin
      retry_q <= retry_q + 4'd1;
    end
  end

  assign retry_ok = (retry_q < MAX_RETRY_W);
  assign restart  = nack_q & retry_ok;
  assign reload_w = word_q;
`else
  assign retry_ok = 1'b0;
  assign restart  = 1'b0;
  assign reload_w = '0;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      go_q    <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      nack_q  <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
      end_q   <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      go_q    <= GO;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      nack_q  <= nack_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = '0;
    if (state_q != S_IDLE && !tick) cnt_d = cnt_q + 10'd1;
    if (launch) begin
      state_d = S_START;
      ph_d    = '0;
    end else if (tick) begin
      ph_d = ph_q + 2'd1;
      if (ph_q == 2'd3) begin
        case (state_q)
          S_START:    state_d = S_DATA_BIT;
          S_DATA_BIT: if (bit_q[2:0] == 3'd0) state_d = S_ACK;
          // bit counter saturates at 0, so 0 here means the third byte was acknowledged
          S_ACK:      state_d = (nack_q || bit_q == 5'd0) ? S_STOP : S_DATA_BIT;
          S_STOP:     state_d = restart ? S_START : S_IDLE;
          default:    state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    nack_d  = nack_q;
    scl_d   = scl_q;
    oe_d    = oe_q;
    end_d   = end_q;
    busy_d  = busy_q;
    err_d   = err_q;
    if (launch) begin
      shift_d = DATA;
      bit_d   = 5'd23;
      nack_d  = 1'b0;
      err_d   = 1'b0;
      busy_d  = 1'b1;
      end_d   = 1'b0;
    end else if (tick) begin
      case (state_q)
        S_START: begin
          case (ph_q)
            2'd0: begin scl_d = 1'b1; oe_d = 1'b0; end
            2'd1: oe_d = 1'b1;
            2'd3: scl_d = 1'b0;
            default: ;
          endcase
        end
        S_DATA_BIT: begin
          case (ph_q)
            2'd0: begin scl_d = 1'b0; oe_d = ~shift_q[23]; end
            2'd1: scl_d = 1'b1;
            2'd3: begin
              scl_d   = 1'b0;
              shift_d = {shift_q[22:0], 1'b0};
              if (bit_q != 5'd0) bit_d = bit_q - 5'd1;
            end
            default: ;
          endcase
        end
        S_ACK: begin
          case (ph_q)
            2'd0: oe_d = 1'b0;
            2'd1: scl_d = 1'b1;
            2'd2: begin
              nack_d = I2C_SDAT_IN;
              if (I2C_SDAT_IN && !retry_ok) err_d = 1'b1;
            end
            2'd3: scl_d = 1'b0;
            default: ;
          endcase
        end
        S_STOP: begin
          case (ph_q)
            2'd0: begin scl_d = 1'b0; oe_d = 1'b1; end
            2'd1: scl_d = 1'b1;
            2'd2: oe_d = 1'b0;
            2'd3: begin
              if (restart) begin
                shift_d = reload_w;
                bit_d   = 5'd23;
                nack_d  = 1'b0;
              end else begin
                end_d  = 1'b1;
                busy_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign I2C_SCLK    = scl_q;
  assign I2C_SDAT_OE = oe_q;
  assign END         = end_q;
  assign BUSY        = busy_q;
  assign ACK_ERR     = err_q;

endmodule

// File: tb/tb_i2c_cfg_writer.sv
// Self-checking bench for i2c_cfg_writer: transaction-level model, I2C bus decoder and slave.
module tb_i2c_cfg_writer;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_RETRY = 3;
`ifdef I2C_ACK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        GO    = 1'b0;
  logic [23:0] DATA  = '0;
  logic        I2C_SCLK, I2C_SDAT_OE, I2C_SDAT_IN, END, BUSY, ACK_ERR;
  logic        slave_pull = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  assign I2C_SDAT_IN = ~(I2C_SDAT_OE | slave_pull);
  always #5 CLOCK = ~CLOCK;

  i2c_cfg_writer #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .GO         (GO),
    .DATA       (DATA),
    .I2C_SCLK   (I2C_SCLK),
    .I2C_SDAT_OE(I2C_SDAT_OE),
    .I2C_SDAT_IN(I2C_SDAT_IN),
    .END        (END),
    .BUSY       (BUSY),
    .ACK_ERR    (ACK_ERR)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: per-attempt NACK plan (0 = all ACK, n = NACK byte n)
  int          nack_plan [8];
  logic [9:0]  exp_q [$];
  bit          m_busy, m_err, m_next_err, go_prev;
  int          m_left, exp_starts, m_launches;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      m_busy = 1'b0; m_err = 1'b0; go_prev = 1'b0; m_left = 0;
      exp_q.delete();
    end else begin
      if (GO && !go_prev && !m_busy) begin
        int slots;
        slots = 0;
        m_launches++;
        for (int a = 0; a < 8; a++) begin
          int n, nb;
          n  = nack_plan[a];
          nb = (n == 0) ? 3 : n;
          for (int b = 1; b <= nb; b++)
            exp_q.push_back({1'b0, 1'(b == n), 8'((DATA >> (8 * (3 - b))) & 24'hFF)});
          slots += (n == 0) ? 29 : 2 + 9 * n;
          exp_starts++;
          m_next_err = (n != 0);
          if (n == 0 || !RETRY_EN || a >= int'(MAX_RETRY)) break;
        end
        m_left = 4 * int'(CLK_DIV) * slots;
        m_busy = 1'b1;
        m_err  = 1'b0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_err  = m_next_err;
        end
      end
      go_prev = GO;
    end
  end

  always @(negedge CLOCK) begin
    if (!RESET && chk_en) begin
      check("end", END, !m_busy);
      check("busy", BUSY, m_busy);
      if (!m_busy) begin
        check("idle_scl", I2C_SCLK, 1);
        check("idle_sda_oe", I2C_SDAT_OE, 0);
        check("ack_err", ACK_ERR, m_err);
      end
    end
  end

  // Bus decoder and slave: START/STOP are SDA edges while SCL stays high
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] shreg = '0;
  logic       ackb = 1'b0;
  bit         in_frame = 1'b0;
  int         bitn, byte_idx, attempt, n_start, n_stop, scl_edges;

  always @(negedge CLOCK) begin
    if (RESET) begin
      in_frame = 1'b0; bitn = 0; slave_pull = 1'b0;
    end else begin
      if (!BUSY) attempt = 0;
      if (I2C_SCLK != scl_p) scl_edges++;
      if (scl_p && I2C_SCLK && sda_p && !I2C_SDAT_IN) begin
        n_start++; in_frame = 1'b1; bitn = 0; byte_idx = 0;
      end else if (scl_p && I2C_SCLK && !sda_p && I2C_SDAT_IN) begin
        n_stop++; in_frame = 1'b0;
        if (attempt < 7) attempt++;
      end else if (!scl_p && I2C_SCLK && in_frame) begin
        if (bitn < 8) shreg = {shreg[6:0], I2C_SDAT_IN};
        else if (bitn == 8) ackb = I2C_SDAT_IN;
        bitn++;
      end else if (scl_p && !I2C_SCLK && in_frame) begin
        if (bitn == 8) begin
          byte_idx++;
          slave_pull = (nack_plan[attempt] != byte_idx);
        end else if (bitn == 9) begin
          slave_pull = 1'b0;
          bitn = 0;
          check("bus_byte", {1'b0, ackb, shreg}, exp_q.size() != 0 ? exp_q.pop_front() : 10'h3FF);
        end
      end
    end
    scl_p = I2C_SCLK;
    sda_p = I2C_SDAT_IN;
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 5000 && !END) begin @(negedge CLOCK); n++; end
    check({nm, "_timeout"}, END, 1);
  endtask

  task automatic run_xfer(input logic [23:0] w, input int lat, input string nm);
    int n;
    @(negedge CLOCK); DATA = w; GO = 1'b1;
    @(negedge CLOCK); GO = 1'b0; DATA = ~w;
    check({nm, "_busy"}, BUSY, 1);
    check({nm, "_err_clr"}, ACK_ERR, 0);
    n = 0;
    while (n < 5000) begin
      @(posedge CLOCK); #1; n++;
      if (END) break;
    end
    check({nm, "_latency"}, n, lat);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_scl"}, I2C_SCLK, 1);
    check({nm, "_oe"}, I2C_SDAT_OE, 0);
    check({nm, "_end"}, END, 1);
    check({nm, "_busy"}, BUSY, 0);
    check({nm, "_err"}, ACK_ERR, 0);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 8; i++) nack_plan[i] = 0;
    #1 RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check_reset_vals("reset");
    RESET = 1'b0;
    chk_en = 1'b1;
    repeat (1000) @(negedge CLOCK);
    check("idle_scl_edges", scl_edges, 0);

    run_xfer(24'h340C00, 464, "ack_all_340C00");
    check("err_after_ack_all", ACK_ERR, 0);
    run_xfer(24'h34A55A, 464, "ack_all_34A55A");

`ifndef I2C_ACK_RETRY_EN
    nack_plan[0] = 2;
    run_xfer(24'h341234, 320, "nack_byte2");
    check("err_after_nack2", ACK_ERR, 1);
    nack_plan[0] = 1;
    run_xfer(24'h34FF01, 176, "nack_byte1");
    nack_plan[0] = 3;
    run_xfer(24'h348001, 464, "nack_byte3");
    check("err_after_nack3", ACK_ERR, 1);
    nack_plan[0] = 0;
    run_xfer(24'h340E55, 464, "ack_after_nack");
    check("err_cleared", ACK_ERR, 0);
`else
    s0 = n_start;
    nack_plan[0] = 1; nack_plan[1] = 1;
    run_xfer(24'h341234, 816, "retry_then_ack");
    check("retry_starts", n_start - s0, 3);
    check("retry_err", ACK_ERR, 0);
    s0 = n_start;
    for (int i = 0; i < 8; i++) nack_plan[i] = 1;
    run_xfer(24'h34FF01, 704, "retry_exhausted");
    check("exhausted_starts", n_start - s0, 4);
    check("exhausted_err", ACK_ERR, 1);
    for (int i = 0; i < 8; i++) nack_plan[i] = 0;
`endif

    // GO toggling during a transfer must not queue a second launch
    s0 = n_start;
    begin
      int base;
      base = m_launches;
      @(negedge CLOCK); DATA = 24'h3401AA;
      for (int i = 0; i < 3000 && m_launches < base + 2; i++) begin
        @(negedge CLOCK);
        if (i % 50 == 0) GO = ~GO;
        if (BUSY) DATA = 24'h340255;
      end
      GO = 1'b0;
      @(negedge CLOCK);
      wait_idle("toggle_second");
      check("toggle_launches", m_launches - base, 2);
    end
    check("toggle_starts", n_start - s0, 2);
    check("stops_balance", n_stop, exp_starts);

    // Asynchronous reset during slot 10
    @(negedge CLOCK); DATA = 24'h34C3C3; GO = 1'b1;
    @(negedge CLOCK); GO = 1'b0;
    repeat (165) @(negedge CLOCK);
    check("pre_reset_busy", BUSY, 1);
    #2 RESET = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge CLOCK); @(negedge CLOCK);
    RESET = 1'b0;
    run_xfer(24'h340F3C, 464, "after_reset");
    check("starts_total", n_start, exp_starts);
    check("exp_queue_empty", exp_q.size(), 0);

    repeat (20) @(negedge CLOCK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
